sb_pattern_gen_param: RTL and testbench
=======================================

Name: sb_pattern_gen_param

Overview:
- Parametrised successor of the sideband TX pattern generator. Drives the clock-pattern stream (repeating 2'b10) to the sideband serializer during SBINIT.
- Alternates 1 ms send windows with 1 ms sleep windows.
- On RX sample-done it sends EXTRA_ITER further patterns, then signals done to LTSM. It times out after TIMEOUT_MS.
- Adds explicit FSM, abort, busy flag and parametrised width/timing.

Parameters:
- PATTERN_W, 64, pattern word width; must be even and >= 2.
- MS_CYCLES, 100, i_clk cycles per 1 ms window; must be >= 2.
- TIMEOUT_MS, 8, number of elapsed ms windows before timeout; must be >= 1.
- EXTRA_ITER, 4, patterns sent after i_rx_sb_pattern_samp_done; must be >= 1.

Ports:
- i_clk  in  1  clock
- i_rst_n  in  1  asynchronous active-low reset
- i_start_pattern_req  in  1  LTSM request; level or pulse, sampled only in IDLE
- i_rx_sb_pattern_samp_done  in  1  local RX detected pattern; pulse
- i_ser_done  in  1  serializer finished current word; pulse
- i_abort  in  1  synchronous abort to IDLE
- o_start_pattern_done  out  1  one-cycle pulse, sequence complete
- o_pattern_time_out  out  1  one-cycle pulse, timeout
- o_pattern  out  PATTERN_W  {PATTERN_W/2{2'b10}} while active
- o_pattern_valid  out  1  one-cycle pulse per word issued
- o_busy  out  1  high in any state except IDLE

Behaviour:
- Reset (async, i_rst_n=0): state IDLE; all counters 0; pending flag 0; all outputs 0 (o_pattern = 0).
- States: IDLE, SEND, SLEEP, TAIL, DONE, TOUT. Encoding comes from the package enum.
- IDLE:
  - i_start_pattern_req=1 -> SEND.
  - Next cycle: o_pattern_valid=1 and o_pattern loaded. Latency is 1 cycle.
  - ms counter and ms-window counter start from 0.
- SEND:
  - Each i_ser_done -> o_pattern_valid=1 the next cycle.
  - The ms counter wrapping at MS_CYCLES-1 -> SLEEP.
- SLEEP:
  - No valid is issued.
  - i_ser_done is captured in a pending flag.
  - The ms counter wrapping -> SEND. If pending=1, a valid is issued on the first SEND cycle and pending clears.
- Window count: incremented at each ms wrap in SEND or SLEEP. On the wrap where the count reaches TIMEOUT_MS -> TOUT instead of toggling. With defaults this is exactly 800 cycles after the request was accepted.
- TOUT: o_pattern_time_out=1 for one cycle; o_pattern_valid=0; then IDLE.
- i_rx_sb_pattern_samp_done in SEND or SLEEP -> TAIL:
  - Tail counter = 0 and the ms timer is frozen.
  - The first tail pattern is issued the next cycle, regardless of window.
  - Each subsequent i_ser_done issues another pattern.
  - After EXTRA_ITER issued patterns, the next i_ser_done -> DONE. This final i_ser_done issues no valid.
- DONE: o_start_pattern_done=1 for one cycle; then IDLE.
- Simultaneous events:
  - samp_done on the same cycle as the timeout wrap: samp_done wins (TAIL).
  - samp_done in IDLE, TAIL, DONE or TOUT: ignored.
  - i_ser_done in IDLE: ignored.
  - i_ser_done together with samp_done in SEND: the TAIL first pattern covers it; only one valid is issued.
- i_abort: highest priority after reset. Any state -> IDLE next cycle; counters and pending cleared; o_pattern_valid=0; no done or timeout pulse.
- o_pattern is driven 0 in IDLE and holds the pattern constant otherwise.
- Counter widths are $clog2 of their range plus 1. There is no wrap-around beyond the terminal values.

Optional Feature:
- Macro SB_PAT_ITER_CNT_EN.
- Defined: adds output o_iter_count (16 bits), the count of valid pulses since the last IDLE exit. It saturates at 16'hFFFF and clears on entering IDLE, including on abort.
- Undefined: the port is absent. No other behaviour changes.

Decomposition:
- Package sb_pattern_pkg holds:
  - the state enum sb_pat_state_e;
  - SB_CLK_PATTERN_UNIT = 2'b10;
  - a function returning the replicated pattern for a given width.
- Sub-module sb_ms_timer (parameter MS_CYCLES, TIMEOUT_MS):
  - inputs clear/enable/freeze;
  - outputs ms_tick and timeout_tick.
- The FSM and valid/pending logic stay in the top module.

Test Plan:
- Defaults; req pulse at t0; i_ser_done 20 cycles after each valid; no samp_done -> valids only in SEND windows; o_pattern=64'hAAAA_AAAA_AAAA_AAAA; o_pattern_time_out pulse at t0+801; busy low afterwards.
- i_ser_done in SLEEP at cycle 150 -> no valid in SLEEP; one valid on cycle 201 (first SEND cycle of window 3); pending cleared.
- samp_done at cycle 120 (SLEEP) -> valid at 121; 3 more valids on successive i_ser_done; done pulse one cycle after the 5th i_ser_done; no timeout.
- samp_done on the same cycle as the 8th ms wrap -> TAIL entered, no o_pattern_time_out, done after 4 patterns.
- i_abort at cycle 50 mid-SEND -> IDLE next cycle; no done or timeout pulse; a new req restarts with timeout again at +800.
- PATTERN_W=32, MS_CYCLES=10, TIMEOUT_MS=2, EXTRA_ITER=1 -> o_pattern=32'hAAAA_AAAA; timeout at req+21. With SB_PAT_ITER_CNT_EN defined, o_iter_count matches the number of valid pulses.

Source files
------------

// File: rtl/sb_pattern_pkg.sv
// -----------------------------------------------------------------------------
// sb_pattern_pkg
// Shared definitions for the sideband TX clock-pattern generator:
//   - sb_pat_state_e      : FSM state encoding used by sb_pattern_gen_param
//   - SB_CLK_PATTERN_UNIT : the 2-bit clock-pattern unit (2'b10)
//   - sb_clk_pattern()    : returns the unit replicated across a word of the
//                           requested width (LSB-aligned inside SB_PAT_MAX_W)
// -----------------------------------------------------------------------------
package sb_pattern_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SEND  = 3'd1,
    ST_SLEEP = 3'd2,
    ST_TAIL  = 3'd3,
    ST_DONE  = 3'd4,
    ST_TOUT  = 3'd5
  } sb_pat_state_e;

  localparam logic [1:0] SB_CLK_PATTERN_UNIT = 2'b10;

  // Widest pattern word the helper can build; PATTERN_W must not exceed it.
  localparam int SB_PAT_MAX_W = 1024;

  // Replicates SB_CLK_PATTERN_UNIT width/2 times; bits above width stay 0.
  function automatic logic [SB_PAT_MAX_W-1:0] sb_clk_pattern(input int width);
    logic [SB_PAT_MAX_W-1:0] pat;
    pat = '0;
    for (int i = 0; i < SB_PAT_MAX_W / 2; i++) begin
      if (i < width / 2) pat[2*i +: 2] = SB_CLK_PATTERN_UNIT;
    end
    return pat;
  endfunction

endpackage

// File: rtl/sb_ms_timer.sv
// -----------------------------------------------------------------------------
// sb_ms_timer
// Millisecond window timer for the sideband pattern generator. Counts clk
// cycles inside a 1 ms window and counts elapsed windows, saturating at
// TIMEOUT_MS.
//
// Ports:
//   clk, rst_n    : clock, asynchronous active-low reset
//   clear         : synchronous clear of both counters (highest priority)
//   enable        : counters advance while high
//   freeze        : holds both counters even when enable is high
//   ms_tick       : combinational, high on the last cycle of a window
//   timeout_tick  : combinational, high on the ms_tick that completes window
//                   number TIMEOUT_MS
// -----------------------------------------------------------------------------
module sb_ms_timer #(
  parameter int MS_CYCLES  = 100,
  parameter int TIMEOUT_MS = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  input  logic freeze,
  output logic ms_tick,
  output logic timeout_tick
);

  localparam int MS_W  = $clog2(MS_CYCLES) + 1;
  localparam int WIN_W = $clog2(TIMEOUT_MS) + 1;

  localparam logic [MS_W-1:0]  MS_LAST  = MS_W'(MS_CYCLES - 1);
  localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(TIMEOUT_MS - 1);
  localparam logic [WIN_W-1:0] WIN_MAX  = WIN_W'(TIMEOUT_MS);

  logic [MS_W-1:0]  ms_cnt_q,  ms_cnt_d;
  logic [WIN_W-1:0] win_cnt_q, win_cnt_d;
  logic             advance;

  assign advance      = enable & ~freeze;
  assign ms_tick      = advance & (ms_cnt_q == MS_LAST);
  // The window counter still holds the pre-increment value on the tick.
  assign timeout_tick = ms_tick & (win_cnt_q == WIN_LAST);

  always_comb begin
    // NOTE: every combinational output gets a default first so no path
    // through the block leaves it unassigned (which would infer a latch).
    ms_cnt_d  = ms_cnt_q;
    win_cnt_d = win_cnt_q;
    if (clear) begin
      ms_cnt_d  = '0;
      win_cnt_d = '0;
    end else if (advance) begin
      ms_cnt_d = ms_tick ? '0 : ms_cnt_q + 1'b1;
      if (ms_tick && (win_cnt_q != WIN_MAX)) win_cnt_d = win_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: flops are updated with non-blocking assignments so every flop
    // samples its pre-edge inputs regardless of statement order.
    if (!rst_n) begin
      ms_cnt_q  <= '0;
      win_cnt_q <= '0;
    end else begin
      ms_cnt_q  <= ms_cnt_d;
      win_cnt_q <= win_cnt_d;
    end
  end

endmodule

// File: rtl/sb_pattern_gen_param.sv
// -----------------------------------------------------------------------------
// sb_pattern_gen_param
// Sideband TX clock-pattern generator used during SBINIT. Issues words of
// repeating 2'b10 to the serializer, alternating 1 ms send windows with 1 ms
// sleep windows, until the local RX reports the pattern was sampled (then
// EXTRA_ITER tail patterns and a done pulse) or TIMEOUT_MS windows elapse
// (timeout pulse). i_abort returns to IDLE from any state.
//
// Ports:
//   i_clk, i_rst_n             : clock, asynchronous active-low reset
//   i_start_pattern_req        : start request, sampled only in IDLE
//   i_rx_sb_pattern_samp_done  : RX saw the pattern (pulse)
//   i_ser_done                 : serializer consumed the current word (pulse)
//   i_abort                    : synchronous return to IDLE
//   o_start_pattern_done       : one-cycle pulse, sequence complete
//   o_pattern_time_out         : one-cycle pulse, timeout
//   o_pattern                  : pattern word, 0 in IDLE
//   o_pattern_valid            : one-cycle pulse per word issued
//   o_busy                     : high in every state except IDLE
//   o_iter_count               : (only with SB_PAT_ITER_CNT_EN) valid pulses
//                                since leaving IDLE, saturating at 16'hFFFF
//
// Optional feature macro: SB_PAT_ITER_CNT_EN
// -----------------------------------------------------------------------------
module sb_pattern_gen_param
  import sb_pattern_pkg::*;
#(
  parameter int PATTERN_W  = 64,
  parameter int MS_CYCLES  = 100,
  parameter int TIMEOUT_MS = 8,
  parameter int EXTRA_ITER = 4
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_start_pattern_req,
  input  logic                 i_rx_sb_pattern_samp_done,
  input  logic                 i_ser_done,
  input  logic                 i_abort,
  output logic                 o_start_pattern_done,
  output logic                 o_pattern_time_out,
  output logic [PATTERN_W-1:0] o_pattern,
  output logic                 o_pattern_valid,
  output logic                 o_busy
`ifdef SB_PAT_ITER_CNT_EN
  ,
  output logic [15:0]          o_iter_count
`endif
);

  localparam logic [SB_PAT_MAX_W-1:0] PAT_FULL = sb_clk_pattern(PATTERN_W);
  localparam logic [PATTERN_W-1:0]    PAT_WORD = PAT_FULL[PATTERN_W-1:0];

  localparam int                  TAIL_W    = $clog2(EXTRA_ITER) + 1;
  localparam logic [TAIL_W-1:0]   TAIL_LAST = TAIL_W'(EXTRA_ITER - 1);

  sb_pat_state_e         state_q, state_d;
  // Tail patterns issued after the first one (0 .. EXTRA_ITER-1).
  logic [TAIL_W-1:0]     tail_cnt_q, tail_cnt_d;
  logic                  pending_q, pending_d;
  logic                  valid_q, valid_d;
  logic                  done_q, done_d;
  logic                  tout_q, tout_d;
  logic                  busy_q, busy_d;
  logic [PATTERN_W-1:0]  pattern_q, pattern_d;

  logic timer_clear, timer_enable, timer_freeze;
  logic ms_tick, timeout_tick;

  assign timer_clear  = (state_q == ST_IDLE) | i_abort;
  assign timer_enable = (state_q == ST_SEND) | (state_q == ST_SLEEP);
  assign timer_freeze = (state_q == ST_TAIL);

  sb_ms_timer #(
    .MS_CYCLES  (MS_CYCLES),
    .TIMEOUT_MS (TIMEOUT_MS)
  ) u_ms_timer (
    .clk          (i_clk),
    .rst_n        (i_rst_n),
    .clear        (timer_clear),
    .enable       (timer_enable),
    .freeze       (timer_freeze),
    .ms_tick      (ms_tick),
    .timeout_tick (timeout_tick)
  );

  always_comb begin
    state_d    = state_q;
    tail_cnt_d = tail_cnt_q;
    pending_d  = pending_q;
    valid_d    = 1'b0;
    done_d     = 1'b0;
    tout_d     = 1'b0;

    if (i_abort) begin
      state_d    = ST_IDLE;
      tail_cnt_d = '0;
      pending_d  = 1'b0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (i_start_pattern_req) begin
            state_d    = ST_SEND;
            valid_d    = 1'b1;
            tail_cnt_d = '0;
            pending_d  = 1'b0;
          end
        end

        ST_SEND, ST_SLEEP: begin
          if (i_rx_sb_pattern_samp_done) begin
            // Sample-done beats a coinciding timeout; the first tail word
            // also covers any i_ser_done seen this cycle.
            state_d    = ST_TAIL;
            valid_d    = 1'b1;
            tail_cnt_d = '0;
            pending_d  = 1'b0;
          end else if (timeout_tick) begin
            state_d   = ST_TOUT;
            tout_d    = 1'b1;
            pending_d = 1'b0;
          end else if (ms_tick) begin
            if (state_q == ST_SEND) begin
              // A word finished on the last send cycle waits for the next
              // send window instead of being issued during sleep.
              state_d   = ST_SLEEP;
              pending_d = i_ser_done;
            end else begin
              state_d   = ST_SEND;
              valid_d   = pending_q | i_ser_done;
              pending_d = 1'b0;
            end
          end else if (i_ser_done) begin
            if (state_q == ST_SEND) valid_d = 1'b1;
            else                    pending_d = 1'b1;
          end
        end

        ST_TAIL: begin
          if (i_ser_done) begin
            if (tail_cnt_q == TAIL_LAST) begin
              state_d = ST_DONE;
              done_d  = 1'b1;
            end else begin
              tail_cnt_d = tail_cnt_q + 1'b1;
              valid_d    = 1'b1;
            end
          end
        end

        ST_DONE: state_d = ST_IDLE;
        ST_TOUT: state_d = ST_IDLE;

        default: state_d = ST_IDLE;
      endcase
    end

    busy_d    = (state_d != ST_IDLE);
    pattern_d = busy_d ? PAT_WORD : '0;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q    <= ST_IDLE;
      tail_cnt_q <= '0;
      pending_q  <= 1'b0;
      valid_q    <= 1'b0;
      done_q     <= 1'b0;
      tout_q     <= 1'b0;
      busy_q     <= 1'b0;
      pattern_q  <= '0;
    end else begin
      state_q    <= state_d;
      tail_cnt_q <= tail_cnt_d;
      pending_q  <= pending_d;
      valid_q    <= valid_d;
      done_q     <= done_d;
      tout_q     <= tout_d;
      busy_q     <= busy_d;
      pattern_q  <= pattern_d;
    end
  end

  assign o_start_pattern_done = done_q;
  assign o_pattern_time_out   = tout_q;
  assign o_pattern            = pattern_q;
  assign o_pattern_valid      = valid_q;
  assign o_busy               = busy_q;

`ifdef SB_PAT_ITER_CNT_EN
  logic [15:0] iter_cnt_q, iter_cnt_d;

  // Tracks o_pattern_valid: cleared whenever the next state is IDLE.
  always_comb begin
    iter_cnt_d = iter_cnt_q;
    if (state_d == ST_IDLE)                        iter_cnt_d = '0;
    else if (valid_d && (iter_cnt_q != 16'hFFFF))  iter_cnt_d = iter_cnt_q + 16'd1;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) iter_cnt_q <= '0;
    else          iter_cnt_q <= iter_cnt_d;
  end

  assign o_iter_count = iter_cnt_q;
`endif

endmodule

// File: tb/tb_sb_pattern_gen_param.sv
// -----------------------------------------------------------------------------
// tb_sb_pattern_gen_param
// Two instances: u_small (W=32, MS=10, TIMEOUT=2, EXTRA=1) driven from a
// per-cycle vector table, and u_def (defaults) driven by directed sequences
// with a 20-cycle serializer model. Optional macro: SB_PAT_ITER_CNT_EN.
// -----------------------------------------------------------------------------
module tb_sb_pattern_gen_param;

  localparam logic [63:0] PAT64 = 64'hAAAA_AAAA_AAAA_AAAA;
  localparam logic [31:0] PAT32 = 32'hAAAA_AAAA;
  localparam int LOG_N = 1024;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // default instance
  logic        d_req = 0, d_samp = 0, d_ser = 0, d_abort = 0;
  logic        d_done, d_tout, d_valid, d_busy;
  logic [63:0] d_pat;
  logic [15:0] d_iter;
  // small instance
  logic        s_req = 0, s_samp = 0, s_ser = 0, s_abort = 0;
  logic        s_done, s_tout, s_valid, s_busy;
  logic [31:0] s_pat;
  logic [15:0] s_iter;

`ifndef SB_PAT_ITER_CNT_EN
  assign d_iter = '0;
  assign s_iter = '0;
`endif

  sb_pattern_gen_param u_def (
    .i_clk                     (clk),
    .i_rst_n                   (rst_n),
    .i_start_pattern_req       (d_req),
    .i_rx_sb_pattern_samp_done (d_samp),
    .i_ser_done                (d_ser),
    .i_abort                   (d_abort),
    .o_start_pattern_done      (d_done),
    .o_pattern_time_out        (d_tout),
    .o_pattern                 (d_pat),
    .o_pattern_valid           (d_valid),
    .o_busy                    (d_busy)
`ifdef SB_PAT_ITER_CNT_EN
    ,
    .o_iter_count              (d_iter)
`endif
  );

  sb_pattern_gen_param #(
    .PATTERN_W  (32),
    .MS_CYCLES  (10),
    .TIMEOUT_MS (2),
    .EXTRA_ITER (1)
  ) u_small (
    .i_clk                     (clk),
    .i_rst_n                   (rst_n),
    .i_start_pattern_req       (s_req),
    .i_rx_sb_pattern_samp_done (s_samp),
    .i_ser_done                (s_ser),
    .i_abort                   (s_abort),
    .o_start_pattern_done      (s_done),
    .o_pattern_time_out        (s_tout),
    .o_pattern                 (s_pat),
    .o_pattern_valid           (s_valid),
    .o_busy                    (s_busy)
`ifdef SB_PAT_ITER_CNT_EN
    ,
    .o_iter_count              (s_iter)
`endif
  );

  int n_chk = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- vector table for u_small ----------------
  typedef struct {
    bit req, samp, ser, abort;
    bit e_valid, e_done, e_tout, e_busy;
    int e_iter;
  } vec_t;

  vec_t vq[$];

  task automatic add(input bit req, input bit samp, input bit ser, input bit abort,
                     input bit v, input bit d, input bit t, input bit b, input int it);
    vec_t x;
    x.req = req; x.samp = samp; x.ser = ser; x.abort = abort;
    x.e_valid = v; x.e_done = d; x.e_tout = t; x.e_busy = b; x.e_iter = it;
    vq.push_back(x);
  endtask

  // ---------------- logs for u_def sequences ----------------
  bit          log_valid [LOG_N];
  bit          log_done  [LOG_N];
  bit          log_tout  [LOG_N];
  bit          log_busy  [LOG_N];
  logic [63:0] log_pat   [LOG_N];

  // Request at cycle 0; cycle c is sampled 1 time unit after edge c.
  task automatic run_def(input bit auto_ser, input int samp_at, input int ser_at,
                         input int abort_at, input int ncyc);
    int ser_cnt;
    bit ser_now;
    ser_cnt = 0;
    for (int c = 0; c < LOG_N; c++) begin
      log_valid[c] = 0; log_done[c] = 0; log_tout[c] = 0; log_busy[c] = 0; log_pat[c] = '0;
    end
    for (int c = 0; c <= ncyc; c++) begin
      log_valid[c] = d_valid;
      log_done[c]  = d_done;
      log_tout[c]  = d_tout;
      log_busy[c]  = d_busy;
      log_pat[c]   = d_pat;
      ser_now = 0;
      if (auto_ser) begin
        if (d_valid) ser_cnt = 20;
        else if (ser_cnt > 0) begin
          ser_cnt--;
          ser_now = (ser_cnt == 0);
        end
      end
      d_req   = (c == 0);
      d_samp  = (c == samp_at);
      d_abort = (c == abort_at);
      d_ser   = ser_now | (c == ser_at);
      @(posedge clk); #1;
    end
    d_req = 0; d_samp = 0; d_ser = 0; d_abort = 1;
    @(posedge clk); #1;
    d_abort = 0;
    @(posedge clk); #1;
  endtask

  function automatic int cnt(input int kind, input int lo, input int hi);
    int n = 0;
    for (int c = lo; c <= hi; c++) begin
      if (kind == 0 && log_valid[c]) n++;
      if (kind == 1 && log_done[c])  n++;
      if (kind == 2 && log_tout[c])  n++;
    end
    return n;
  endfunction

  function automatic int sleep_valids(input int hi);
    int n = 0;
    for (int c = 1; c <= hi; c++)
      if ((((c - 1) / 100) % 2 == 1) && log_valid[c]) n++;
    return n;
  endfunction

  initial begin
    // ---- table: small instance ----
    add(1,0,0,0, 0,0,0,0, 0);                              // 0 IDLE, request
    add(0,0,0,0, 1,0,0,1, 1);                              // 1 first SEND word
    add(0,0,0,0, 0,0,0,1, 1);                              // 2
    add(0,0,1,0, 0,0,0,1, 1);                              // 3 ser_done
    add(0,0,0,0, 1,0,0,1, 2);                              // 4 valid from ser_done
    for (int i = 5; i <= 9; i++) add(0,0,0,0, 0,0,0,1, 2); // 5..9
    add(0,0,1,0, 0,0,0,1, 2);                              // 10 last SEND cycle, ser -> pending
    for (int i = 11; i <= 20; i++) add(0,0,0,0, 0,0,0,1, 2); // 11..20 SLEEP, no valid
    add(0,0,0,0, 0,0,1,1, 2);                              // 21 TOUT pulse
    add(1,0,0,0, 0,0,0,0, 0);                              // 22 IDLE, new request
    add(0,0,0,0, 1,0,0,1, 1);                              // 23
    add(0,0,1,0, 0,0,0,1, 1);                              // 24 ser_done
    add(0,0,0,0, 1,0,0,1, 2);                              // 25
    add(0,1,0,0, 0,0,0,1, 2);                              // 26 samp_done in SEND
    add(0,1,0,0, 1,0,0,1, 3);                              // 27 TAIL first word, samp ignored
    add(0,0,1,0, 0,0,0,1, 3);                              // 28 final ser_done, no valid
    add(0,0,0,0, 0,1,0,1, 3);                              // 29 DONE pulse
    add(1,0,0,0, 0,0,0,0, 0);                              // 30 IDLE, request
    add(0,0,0,0, 1,0,0,1, 1);                              // 31
    add(0,0,1,1, 0,0,0,1, 1);                              // 32 abort beats ser_done
    add(0,1,1,0, 0,0,0,0, 0);                              // 33 IDLE ignores ser/samp
    add(1,0,0,1, 0,0,0,0, 0);                              // 34 abort beats request
    add(0,0,0,0, 0,0,0,0, 0);                              // 35
    add(0,0,0,0, 0,0,0,0, 0);                              // 36

    // ---- reset ----
    #12;
    check("rst d_busy",  d_busy,  0);
    check("rst d_valid", d_valid, 0);
    check("rst d_pat",   d_pat,   0);
    check("rst d_done",  d_done,  0);
    check("rst d_tout",  d_tout,  0);
    check("rst s_pat",   s_pat,   0);
    check("rst s_valid", s_valid, 0);
    check("rst s_iter",  s_iter,  0);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;

    // ---- table run ----
    for (int i = 0; i < vq.size(); i++) begin
      check($sformatf("vec%0d valid", i), s_valid, vq[i].e_valid);
      check($sformatf("vec%0d done", i),  s_done,  vq[i].e_done);
      check($sformatf("vec%0d tout", i),  s_tout,  vq[i].e_tout);
      check($sformatf("vec%0d busy", i),  s_busy,  vq[i].e_busy);
      check($sformatf("vec%0d pat", i),   s_pat,   vq[i].e_busy ? PAT32 : 32'h0);
`ifdef SB_PAT_ITER_CNT_EN
      check($sformatf("vec%0d iter", i),  s_iter,  vq[i].e_iter);
`endif
      s_req = vq[i].req; s_samp = vq[i].samp; s_ser = vq[i].ser; s_abort = vq[i].abort;
      @(posedge clk); #1;
    end
    s_req = 0; s_samp = 0; s_ser = 0; s_abort = 0;

    // ---- abort mid-SEND at cycle 50 ----
    run_def(1, -1, -1, 50, 70);
    check("abort valid43",   log_valid[43], 1);
    check("abort busy50",    log_busy[50], 1);
    check("abort busy51",    log_busy[51], 0);
    check("abort no valid",  cnt(0, 51, 70), 0);
    check("abort no done",   cnt(1, 0, 70), 0);
    check("abort no tout",   cnt(2, 0, 70), 0);

    // ---- plain run to timeout (restart after abort) ----
    run_def(1, -1, -1, -1, 810);
    check("plain pat0",      log_pat[0], 0);
    check("plain valid1",    log_valid[1], 1);
    check("plain pat1",      log_pat[1], PAT64);
    check("plain valid22",   log_valid[22], 1);
    check("plain pend201",   log_valid[201], 1);
    check("plain sleep vld", sleep_valids(800), 0);
    check("plain n_valid",   cnt(0, 0, 810), 20);
    check("plain tout800",   log_tout[800], 0);
    check("plain tout801",   log_tout[801], 1);
    check("plain n_tout",    cnt(2, 0, 810), 1);
    check("plain busy801",   log_busy[801], 1);
    check("plain busy802",   log_busy[802], 0);
    check("plain pat802",    log_pat[802], 0);
    check("plain no done",   cnt(1, 0, 810), 0);

    // ---- ser_done in SLEEP at cycle 150 ----
    run_def(0, -1, 150, -1, 210);
    check("pend sleep vld",  cnt(0, 2, 200), 0);
    check("pend valid201",   log_valid[201], 1);
    check("pend cleared",    cnt(0, 202, 210), 0);
    check("pend n_valid",    cnt(0, 0, 210), 2);

    // ---- samp_done at 120 (SLEEP) ----
    run_def(1, 120, -1, -1, 900);
    check("tail sleep vld",  cnt(0, 101, 120), 0);
    check("tail valid121",   log_valid[121], 1);
    check("tail n_tail",     cnt(0, 121, 204), 4);
    check("tail done204",    log_done[204], 0);
    check("tail done205",    log_done[205], 1);
    check("tail n_done",     cnt(1, 0, 900), 1);
    check("tail no tout",    cnt(2, 0, 900), 0);
    check("tail busy206",    log_busy[206], 0);

    // ---- samp_done on the 8th ms wrap ----
    run_def(1, 800, -1, -1, 900);
    check("race valid801",   log_valid[801], 1);
    check("race no tout",    cnt(2, 0, 900), 0);
    check("race done885",    log_done[885], 1);
    check("race n_done",     cnt(1, 0, 900), 1);
    check("race n_valid",    cnt(0, 0, 900), 24);
    check("race busy886",    log_busy[886], 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
